// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one word-addressed data memory between the pipeline
// MEM stage (m0) and a loader/debug master (m1). One access per cycle, grant
// is combinational, load data and misalignment errors come back one cycle
// after the grant.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int ARB_MODE = 0,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,

    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,

    output logic [CW-1:0] conflict_cnt
);

    typedef enum logic {
        LAST_M0 = 1'b0,
        LAST_M1 = 1'b1
    } lastGnt_t;

    lastGnt_t      lastGnt_q, lastGnt_d;

    logic          m0Rvalid_q, m0Rvalid_d;
    logic [DW-1:0] m0Rdata_q,  m0Rdata_d;
    logic          m0Err_q,    m0Err_d;

    logic          m1Rvalid_q, m1Rvalid_d;
    logic [DW-1:0] m1Rdata_q,  m1Rdata_d;
    logic          m1Err_q,    m1Err_d;

    logic [CW-1:0] conflictCnt_q, conflictCnt_d;

    logic          anyGnt;
    logic          selWe;
    logic [AW-1:0] selAddr;
    logic [DW-1:0] selWdata;
    logic          aligned;
    logic          loadOk;

    // Grant decision: a lone request always wins; a tie goes to the port
    // opposite the last winner, or always to m0 in fixed-priority mode.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                if (ARB_MODE == 1) begin
                    m0_gnt = 1'b1;
                end else if (lastGnt_q == LAST_M1) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // Steer the granted port onto the memory pins; a misaligned access is
    // still driven on A but never writes.
    always_comb begin
        anyGnt   = m0_gnt | m1_gnt;
        selWe    = m1_gnt ? m1_we    : m0_we;
        selAddr  = m1_gnt ? m1_addr  : m0_addr;
        selWdata = m1_gnt ? m1_wdata : m0_wdata;
        aligned  = (selAddr[1:0] == 2'b00);
        loadOk   = anyGnt & aligned & ~selWe;
        mem_a    = selAddr;
        mem_wd   = selWdata;
        mem_we   = anyGnt & aligned & selWe;
    end

    // Next-state for the grant history, the per-port responses and the
    // saturating conflict counter.
    always_comb begin
        lastGnt_d     = lastGnt_q;
        m0Rvalid_d    = m0_gnt & loadOk;
        m0Rdata_d     = m0Rdata_q;
        m0Err_d       = m0_gnt & ~aligned;
        m1Rvalid_d    = m1_gnt & loadOk;
        m1Rdata_d     = m1Rdata_q;
        m1Err_d       = m1_gnt & ~aligned;
        conflictCnt_d = conflictCnt_q;

        if (m0_gnt) begin
            lastGnt_d = LAST_M0;
        end else if (m1_gnt) begin
            lastGnt_d = LAST_M1;
        end

        if (m0_gnt && loadOk) begin
            m0Rdata_d = mem_rd;
        end
        if (m1_gnt && loadOk) begin
            m1Rdata_d = mem_rd;
        end

        if (m0_req && m1_req && (conflictCnt_q != {CW{1'b1}})) begin
            conflictCnt_d = conflictCnt_q + CW'(1);
        end
    end

    // State registers; reset makes m0 win the first tie and drops any
    // response still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGnt_q     <= LAST_M1;
            m0Rvalid_q    <= 1'b0;
            m0Rdata_q     <= '0;
            m0Err_q       <= 1'b0;
            m1Rvalid_q    <= 1'b0;
            m1Rdata_q     <= '0;
            m1Err_q       <= 1'b0;
            conflictCnt_q <= '0;
        end else begin
            lastGnt_q     <= lastGnt_d;
            m0Rvalid_q    <= m0Rvalid_d;
            m0Rdata_q     <= m0Rdata_d;
            m0Err_q       <= m0Err_d;
            m1Rvalid_q    <= m1Rvalid_d;
            m1Rdata_q     <= m1Rdata_d;
            m1Err_q       <= m1Err_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign m0_rvalid    = m0Rvalid_q;
    assign m0_rdata     = m0Rdata_q;
    assign m0_err       = m0Err_q;
    assign m1_rvalid    = m1Rvalid_q;
    assign m1_rdata     = m1Rdata_q;
    assign m1_err       = m1Err_q;
    assign conflict_cnt = conflictCnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives a round-robin arbiter (CW=16) and a fixed-priority
// arbiter (CW=4) with the same requester traffic, each in front of its own
// small word memory, and checks grants, memory pins and responses.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0Req, m0We, m1Req, m1We;
    logic [31:0] m0Addr, m0Wdata, m1Addr, m1Wdata;

    logic        rrM0Gnt, rrM0Rvalid, rrM0Err, rrM1Gnt, rrM1Rvalid, rrM1Err;
    logic [31:0] rrM0Rdata, rrM1Rdata, rrMemA, rrMemWd, rrMemRd;
    logic        rrMemWe;
    logic [15:0] rrCnt;

    logic        fpM0Gnt, fpM0Rvalid, fpM0Err, fpM1Gnt, fpM1Rvalid, fpM1Err;
    logic [31:0] fpM0Rdata, fpM1Rdata, fpMemA, fpMemWd, fpMemRd;
    logic        fpMemWe;
    logic [3:0]  fpCnt;

    logic [31:0] memRr [16];
    logic [31:0] memFp [16];

    int assertCount;
    int failCount;

    dmem_arbiter #(.AW(32), .DW(32), .ARB_MODE(0), .CW(16)) dutRr (
        .clk(clk), .rst(rst),
        .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
        .m0_gnt(rrM0Gnt), .m0_rvalid(rrM0Rvalid), .m0_rdata(rrM0Rdata), .m0_err(rrM0Err),
        .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
        .m1_gnt(rrM1Gnt), .m1_rvalid(rrM1Rvalid), .m1_rdata(rrM1Rdata), .m1_err(rrM1Err),
        .mem_a(rrMemA), .mem_we(rrMemWe), .mem_wd(rrMemWd), .mem_rd(rrMemRd),
        .conflict_cnt(rrCnt)
    );

    dmem_arbiter #(.AW(32), .DW(32), .ARB_MODE(1), .CW(4)) dutFp (
        .clk(clk), .rst(rst),
        .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
        .m0_gnt(fpM0Gnt), .m0_rvalid(fpM0Rvalid), .m0_rdata(fpM0Rdata), .m0_err(fpM0Err),
        .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
        .m1_gnt(fpM1Gnt), .m1_rvalid(fpM1Rvalid), .m1_rdata(fpM1Rdata), .m1_err(fpM1Err),
        .mem_a(fpMemA), .mem_we(fpMemWe), .mem_wd(fpMemWd), .mem_rd(fpMemRd),
        .conflict_cnt(fpCnt)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word memories: combinational read, synchronous write, preloaded with
    // 0x11 at word 0 and 0x22 at word 1 whenever reset is held.
    assign rrMemRd = memRr[rrMemA[5:2]];
    assign fpMemRd = memFp[fpMemA[5:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                memRr[i] <= 32'h0;
                memFp[i] <= 32'h0;
            end
            memRr[0] <= 32'h11;
            memRr[1] <= 32'h22;
            memFp[0] <= 32'h11;
            memFp[1] <= 32'h22;
        end else begin
            if (rrMemWe) memRr[rrMemA[5:2]] <= rrMemWd;
            if (fpMemWe) memFp[fpMemA[5:2]] <= fpMemWd;
        end
    end

    // Drives one cycle's inputs on the falling edge, then waits 1 ns so the
    // caller can sample combinational and registered outputs mid-cycle.
    task automatic applyStimulus(input logic rstV,
                                 input logic r0, input logic w0,
                                 input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1,
                                 input logic [31:0] a1, input logic [31:0] d1);
        @(negedge clk);
        rst     = rstV;
        m0Req   = r0;
        m0We    = w0;
        m0Addr  = a0;
        m0Wdata = d0;
        m1Req   = r1;
        m1We    = w1;
        m1Addr  = a1;
        m1Wdata = d1;
        #1;
    endtask

    // Single comparison point; counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst = 1'b1;
        m0Req = 1'b0; m0We = 1'b0; m0Addr = 32'h0; m0Wdata = 32'h0;
        m1Req = 1'b0; m1We = 1'b0; m1Addr = 32'h0; m1Wdata = 32'h0;

        // Reset held with both requesting: no grants, no write.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 32'h5, 1'b1, 1'b1, 32'h4, 32'h6);
        checkOutput("rst_m0_gnt", 32'(rrM0Gnt), 32'd0);
        checkOutput("rst_m1_gnt", 32'(rrM1Gnt), 32'd0);
        checkOutput("rst_mem_we", 32'(rrMemWe), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("reset_m0_rvalid", 32'(rrM0Rvalid), 32'd0);
        checkOutput("reset_m0_rdata", rrM0Rdata, 32'h0);
        checkOutput("reset_m0_err", 32'(rrM0Err), 32'd0);
        checkOutput("reset_m1_rvalid", 32'(rrM1Rvalid), 32'd0);
        checkOutput("reset_cnt", 32'(rrCnt), 32'd0);

        // m0 alone: store 0xAA to 0x8.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h8, 32'hAA, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("a1_m0_gnt", 32'(rrM0Gnt), 32'd1);
        checkOutput("a1_m1_gnt", 32'(rrM1Gnt), 32'd0);
        checkOutput("a1_mem_we", 32'(rrMemWe), 32'd1);
        checkOutput("a1_mem_a", rrMemA, 32'h8);
        checkOutput("a1_mem_wd", rrMemWd, 32'hAA);

        // m0 alone: load 0x8 right after the store.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("a2_m0_gnt", 32'(rrM0Gnt), 32'd1);
        checkOutput("a2_mem_we", 32'(rrMemWe), 32'd0);
        checkOutput("a2_store_no_rvalid", 32'(rrM0Rvalid), 32'd0);

        // m1 alone: load 0x4; m0 load response appears.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        checkOutput("a3_m0_rvalid", 32'(rrM0Rvalid), 32'd1);
        checkOutput("a3_m0_rdata_raw", rrM0Rdata, 32'hAA);
        checkOutput("a3_m1_gnt", 32'(rrM1Gnt), 32'd1);
        checkOutput("a3_m0_gnt", 32'(rrM0Gnt), 32'd0);
        checkOutput("a3_m1_rvalid", 32'(rrM1Rvalid), 32'd0);
        checkOutput("a3_m1_err", 32'(rrM1Err), 32'd0);

        // Four-cycle tie: round-robin m0,m1,m0,m1; fixed priority always m0.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        checkOutput("b1_rr_m0_gnt", 32'(rrM0Gnt), 32'd1);
        checkOutput("b1_rr_m1_gnt", 32'(rrM1Gnt), 32'd0);
        checkOutput("b1_m1_rvalid", 32'(rrM1Rvalid), 32'd1);
        checkOutput("b1_m1_rdata", rrM1Rdata, 32'h22);
        checkOutput("b1_m0_rvalid", 32'(rrM0Rvalid), 32'd0);
        checkOutput("b1_m0_rdata_hold", rrM0Rdata, 32'hAA);
        checkOutput("b1_fp_m0_gnt", 32'(fpM0Gnt), 32'd1);
        checkOutput("b1_fp_m1_gnt", 32'(fpM1Gnt), 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        checkOutput("b2_rr_m1_gnt", 32'(rrM1Gnt), 32'd1);
        checkOutput("b2_rr_m0_gnt", 32'(rrM0Gnt), 32'd0);
        checkOutput("b2_m0_rvalid", 32'(rrM0Rvalid), 32'd1);
        checkOutput("b2_m0_rdata", rrM0Rdata, 32'h11);
        checkOutput("b2_fp_m0_gnt", 32'(fpM0Gnt), 32'd1);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        checkOutput("b3_rr_m0_gnt", 32'(rrM0Gnt), 32'd1);
        checkOutput("b3_m1_rvalid", 32'(rrM1Rvalid), 32'd1);
        checkOutput("b3_m0_rvalid", 32'(rrM0Rvalid), 32'd0);
        checkOutput("b3_fp_m1_gnt", 32'(fpM1Gnt), 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        checkOutput("b4_rr_m1_gnt", 32'(rrM1Gnt), 32'd1);
        checkOutput("b4_m0_rvalid", 32'(rrM0Rvalid), 32'd1);
        checkOutput("b4_fp_m0_gnt", 32'(fpM0Gnt), 32'd1);
        checkOutput("b4_fp_m1_gnt", 32'(fpM1Gnt), 32'd0);

        // m0 drops: fixed priority finally grants m1.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        checkOutput("b5_fp_m1_gnt", 32'(fpM1Gnt), 32'd1);
        checkOutput("b5_rr_m1_gnt", 32'(rrM1Gnt), 32'd1);
        checkOutput("b5_m1_rvalid", 32'(rrM1Rvalid), 32'd1);
        checkOutput("b5_rr_cnt", 32'(rrCnt), 32'd4);
        checkOutput("b5_fp_cnt", 32'(fpCnt), 32'd4);

        // m1 misaligned store to 0x6: no write, error next cycle only.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h6, 32'hDEAD);
        checkOutput("c1_m1_gnt", 32'(rrM1Gnt), 32'd1);
        checkOutput("c1_mem_we", 32'(rrMemWe), 32'd0);
        checkOutput("c1_m1_rvalid", 32'(rrM1Rvalid), 32'd1);
        checkOutput("c1_m1_err", 32'(rrM1Err), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        checkOutput("c2_m1_err", 32'(rrM1Err), 32'd1);
        checkOutput("c2_m1_rvalid", 32'(rrM1Rvalid), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("c3_m1_err", 32'(rrM1Err), 32'd0);
        checkOutput("c3_m1_rvalid", 32'(rrM1Rvalid), 32'd1);
        checkOutput("c3_m1_rdata", rrM1Rdata, 32'h22);

        // m0 load granted, then reset the next cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("d1_m0_gnt", 32'(rrM0Gnt), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        checkOutput("d2_rst_m0_gnt", 32'(rrM0Gnt), 32'd0);
        checkOutput("d2_rst_m1_gnt", 32'(rrM1Gnt), 32'd0);
        checkOutput("d2_fp_rst_m0_gnt", 32'(fpM0Gnt), 32'd0);

        // Long tie after reset: m0 wins first, round-robin alternates, the
        // 4-bit counter saturates at 0xF while the 16-bit one keeps counting.
        for (int i = 0; i < 19; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
            if (i == 0) begin
                checkOutput("e0_m0_rvalid_cancel", 32'(rrM0Rvalid), 32'd0);
                checkOutput("e0_rr_cnt", 32'(rrCnt), 32'd0);
                checkOutput("e0_fp_cnt", 32'(fpCnt), 32'd0);
                checkOutput("e0_first_tie_m0", 32'(rrM0Gnt), 32'd1);
                checkOutput("e0_first_tie_m1", 32'(rrM1Gnt), 32'd0);
            end
            if (i == 1) begin
                checkOutput("e1_rr_m1_gnt", 32'(rrM1Gnt), 32'd1);
                checkOutput("e1_m0_rvalid", 32'(rrM0Rvalid), 32'd1);
                checkOutput("e1_m0_rdata", rrM0Rdata, 32'h11);
                checkOutput("e1_rr_cnt", 32'(rrCnt), 32'd1);
            end
            if (i == 14) checkOutput("e14_fp_cnt", 32'(fpCnt), 32'd14);
            if (i == 16) checkOutput("e16_fp_cnt_sat", 32'(fpCnt), 32'hF);
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("f_fp_cnt_sat", 32'(fpCnt), 32'hF);
        checkOutput("f_rr_cnt", 32'(rrCnt), 32'd19);
        checkOutput("f_idle_m0_gnt", 32'(rrM0Gnt), 32'd0);
        checkOutput("f_idle_m1_gnt", 32'(rrM1Gnt), 32'd0);
        checkOutput("f_idle_mem_we", 32'(rrMemWe), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port, word-addressed data memory.
- Port m0 serves the pipeline MEM stage; port m1 serves a loader/debug master.
- Issues at most one memory access per cycle, using combinational grant and a registered read/error response.
- Sits between the requesters and the data memory's A/WE/WD/RD pins; the memory write is synchronous and the read is combinational.

Parameters:
- AW, 32, address width in bytes (requester and memory side).
- DW, 32, data width.
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority to m0.
- CW, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  m0 access request; held with its attributes until m0_gnt
- m0_we  in  1  m0 write enable (1 = store, 0 = load)
- m0_addr  in  AW  m0 byte address
- m0_wdata  in  DW  m0 store data
- m0_gnt  out  1  m0 request accepted this cycle (combinational)
- m0_rvalid  out  1  m0 load data valid (registered)
- m0_rdata  out  DW  m0 load data (registered)
- m0_err  out  1  m0 misaligned-access response (registered)
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: identical set for m1
- mem_a  out  AW  to memory A
- mem_we  out  1  to memory WE
- mem_wd  out  DW  to memory WD
- mem_rd  in  DW  from memory RD (combinational read of mem_a)
- conflict_cnt  out  CW  saturating count of cycles with both requests active

Behaviour:
- State: last_gnt (1 bit), per-port rvalid/rdata/err registers, conflict_cnt.
- Reset values: last_gnt=1 (m0 wins the first tie), all rvalid=0, err=0, rdata=0, conflict_cnt=0.
- While rst=1: m0_gnt=m1_gnt=0 and mem_we=0. A reset asserted between grant and response cancels the response.
- Grant (combinational, mutually exclusive):
  - Only one req active: that port is granted.
  - Both active, ARB_MODE=0: grant the port opposite last_gnt.
  - Both active, ARB_MODE=1: always grant m0.
  - No req: no grant; mem_we=0 and mem_a holds the m0 attributes (don't-care).
- last_gnt updates to the granted port on every grant and holds otherwise.
- Alignment: aligned means addr[1:0]==0.
  - Granted aligned request: mem_a=addr and mem_wd=wdata; mem_we=we.
  - Granted misaligned request: mem_we=0 (no memory side effect). The next cycle err=1 for one cycle and rvalid=0.
- Response latency is one cycle.
  - Granted aligned load in cycle N: in cycle N+1 rvalid=1 for one cycle, with rdata = mem_rd sampled at cycle N.
  - Stores produce no rvalid.
  - rdata holds its last value when rvalid=0.
- Read-after-write: a load granted the cycle after a store to the same word returns the new data (memory write completes at the edge ending cycle N).
- Back-to-back: a port may be granted on consecutive cycles; responses pipeline one per cycle.
- conflict_cnt increments each non-reset cycle with m0_req & m1_req, and saturates at all-ones.
- Requester contract: req/we/addr/wdata stay stable until gnt. Dropping req before gnt is legal and withdraws the request.

Test Plan:
- Only m0: store 0x0000_00AA to addr 0x8, then load addr 0x8 -> m0_gnt=1 both cycles; m0_rvalid=1 one cycle after the load with m0_rdata=0x0000_00AA; m1 outputs stay 0.
- Both req (ARB_MODE=0) for 4 cycles, loads to 0x0 and 0x4 -> grants m0,m1,m0,m1; each rvalid lands one cycle after its grant; conflict_cnt=4.
- Both req with ARB_MODE=1 for 3 cycles -> m0_gnt=1 all 3 cycles, m1_gnt=0; m1 granted in the first cycle m0_req drops.
- m1 store to misaligned addr 0x6 -> m1_gnt=1, mem_we=0, m1_err=1 next cycle only; a subsequent load of 0x4 returns the prior value unchanged.
- rst asserted the cycle after an m0 load grant -> m0_rvalid=0, last_gnt=1, conflict_cnt=0; the first post-reset tie grants m0.
- Hold both req for 2^CW+3 cycles with CW=4 -> conflict_cnt saturates at 0xF.
